moore_sec_drv: RTL

- Stimulus driver for the 3-state Moore sequence FSM (states W/X/Y; out=1 only in X).
- Accepts a WIDTH-bit target word and computes, cycle by cycle, the `in` bit that makes the FSM's `out` reproduce the word, LSB first.
- Keeps a shadow copy of the FSM state and checks the FSM's actual `out` against the predicted value.
- Sits on the input side of the FSM, sharing its clk and rst.

---
 rtl/moore_sec_drv.sv | 106 ++++++++++
 1 files changed

// File: rtl/moore_sec_drv.sv
// Stimulus driver for the 3-state Moore sequence FSM (W/X/Y, out=1 only in X).
// Steers the FSM's `in` so its `out` replays a target word LSB first, and checks the fed-back `out`.
module moore_sec_drv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic             drv_in,
    output logic             exp_out,
    input  logic             obs_out,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    input  logic             clr_err
);

    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_X = 2'b01;
    localparam logic [1:0] ST_Y = 2'b10;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       sh_q,       sh_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             mismatch_q, mismatch_d;

    logic want;
    logic accept;

    assign exp_out   = (sh_q == ST_X);
    assign tgt_ready = !busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign accept    = tgt_valid && !busy_q;

    // Desired next FSM output, inverted through the shadow state into the unique `in` bit.
    // Depends only on registered state so the FSM sees no combinational path from our inputs.
    always_comb begin
        want = busy_q ? shreg_q[0] : exp_out;
        case (sh_q)
            ST_W:       drv_in = want;
            ST_X, ST_Y: drv_in = ~want;
            default:    drv_in = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case/if tree, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        sh_d       = ST_W;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mismatch_d = (obs_out != exp_out) || (mismatch_q && !clr_err);

        case (sh_q)
            ST_W:    sh_d = drv_in ? ST_X : ST_Y;
            ST_X:    sh_d = drv_in ? ST_Y : ST_X;
            ST_Y:    sh_d = drv_in ? ST_W : ST_X;
            default: sh_d = ST_W;
        endcase

        if (busy_q) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end
        end else if (accept) begin
            shreg_d = tgt_data;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the shift register is reset too, so an aborted word leaves no stale data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q       <= ST_W;
            shreg_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
        end
    end

endmodule
